// File: rtl/tiny_nn_job_arb.sv
// tiny_nn_job_arb: two-requester round-robin job arbiter feeding a shared 16-bit datapath
module tiny_nn_job_arb #(
    parameter logic [15:0] IdleWord    = 16'h0000,
    parameter logic [15:0] NaNWord     = 16'h7e00,
    parameter int unsigned DrainCycles = 6,
    parameter int unsigned MaxJobLen   = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    input  logic [31:0] req_data_i,
    output logic [1:0]  req_ready_o,
    output logic [1:0]  req_err_o,
    output logic [15:0] nn_data_o,
    input  logic [7:0]  nn_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [7:0]  rsp_data_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {Idle, Issue, Drain} state_t;
    state_t      state_q;
    logic        grant_q;
    logic        ptr_q;
    logic [7:0]  len_q;
    logic [3:0]  drain_q;
    logic [15:0] gnt_word;
    logic        ovf;
    logic        accept;
    logic        abort;
    logic        term;
    logic        winner;
    // Granted-word decode and job-ending conditions; overflow masks the bubble path
    always_comb begin
        gnt_word    = grant_q ? req_data_i[31:16] : req_data_i[15:0];
        ovf         = len_q == 8'(MaxJobLen);
        accept      = state_q == Issue && !ovf && req_valid_i[grant_q];
        abort       = state_q == Issue && (ovf || !req_valid_i[grant_q]);
        term        = accept && gnt_word == NaNWord;
        winner      = &req_valid_i ? ptr_q : req_valid_i[1];
        req_ready_o = accept ? {grant_q, ~grant_q} : 2'b00;
        req_err_o   = abort ? {grant_q, ~grant_q} : 2'b00;
        nn_data_o   = state_q != Issue ? IdleWord : (accept ? gnt_word : NaNWord);
        busy_o      = state_q != Idle;
        rsp_valid_o = busy_o;
        rsp_id_o    = busy_o & grant_q;
        rsp_data_o  = busy_o ? nn_data_i : 8'h00;
    end
    // Job sequencing: arbitrate in Idle, stream in Issue, flush the datapath in Drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            len_q   <= 8'd0;
            drain_q <= 4'd0;
        end else begin
            case (state_q)
                Idle: if (|req_valid_i) begin
                    grant_q <= winner;
                    len_q   <= 8'd0;
                    state_q <= Issue;
                end
                Issue: if (term || abort) begin
                    drain_q <= 4'(DrainCycles - 1);
                    state_q <= Drain;
                end else if (accept) begin
                    len_q <= len_q + 8'd1;
                end
                Drain: begin
                    drain_q <= drain_q - 4'd1;
                    if (drain_q == 4'd0) begin
                        state_q <= Idle;
                        ptr_q   <= ~grant_q;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_tiny_nn_job_arb.sv
// tb_tiny_nn_job_arb: directed scenarios plus randomized job streams checked by a per-requester scoreboard
module tb_tiny_nn_job_arb;
    localparam int MAXL = 4;
    localparam int DC = 6;
    localparam logic [15:0] NAN = 16'h7e00;
    localparam logic [15:0] IDLE = 16'h0000;
    localparam logic [16:0] ERR = 17'h10000;
    localparam logic [16:0] EMPTY = 17'h1ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        tv[2];
    logic [15:0] td[2];
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [1:0]  req_ready_o;
    logic [1:0]  req_err_o;
    logic [15:0] nn_data_o;
    logic [7:0]  nn_i;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [7:0]  rsp_data_o;
    logic        busy_o;
    logic        mon_en;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [16:0] q0[$];
    logic [16:0] q1[$];

    assign req_valid = {tv[1], tv[0]};
    assign req_data  = {td[1], td[0]};

    tiny_nn_job_arb #(.IdleWord(IDLE), .NaNWord(NAN), .DrainCycles(DC), .MaxJobLen(MAXL)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready_o), .req_err_o(req_err_o), .nn_data_o(nn_data_o),
        .nn_data_i(nn_i), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tv[0] = 1'b0;
        tv[1] = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input int n, input logic [16:0] ev);
        if (n == 1) q1.push_back(ev);
        else q0.push_back(ev);
    endtask

    function automatic logic [16:0] pop(input int n);
        if (n == 1) return q1.size() == 0 ? EMPTY : q1.pop_front();
        return q0.size() == 0 ? EMPTY : q0.pop_front();
    endfunction

    task automatic monitor();
        int dr = -1;
        logic [16:0] ev;
        logic endev;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                dr = -1;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (req_ready_o[n]) begin
                        ev = pop(n);
                        check($sformatf("sb_word%0d", n), 32'(nn_data_o), 32'(ev));
                        check($sformatf("sb_id%0d", n), 32'(rsp_id_o), 32'(n));
                    end
                    if (req_err_o[n]) begin
                        ev = pop(n);
                        check($sformatf("sb_err%0d", n), 32'(ev), 32'(ERR));
                        check($sformatf("sb_err_data%0d", n), 32'(nn_data_o), 32'(NAN));
                        check($sformatf("sb_err_id%0d", n), 32'(rsp_id_o), 32'(n));
                    end
                end
                endev = (|req_ready_o && nn_data_o == NAN) || |req_err_o;
                if (dr > 0) begin
                    check("drain_busy", 32'(busy_o), 32'd1);
                    check("drain_quiet", {28'd0, req_ready_o, req_err_o}, 32'd0);
                    check("drain_data", 32'(nn_data_o), 32'(IDLE));
                    dr--;
                end else if (dr == 0) begin
                    check("drain_exit", 32'(busy_o), 32'd0);
                    dr = -1;
                end
                if (endev) dr = DC;
                if (busy_o) begin
                    check("rsp_valid_busy", 32'(rsp_valid_o), 32'd1);
                    check("rsp_data_busy", 32'(rsp_data_o), 32'(nn_i));
                end else begin
                    check("idle_outs", {req_ready_o, req_err_o, nn_data_o, rsp_valid_o, rsp_id_o, rsp_data_o},
                          {4'd0, IDLE, 10'd0});
                end
            end
        end
    endtask

    task automatic drive(input int n, input int jobs);
        logic [15:0] w[$];
        logic [15:0] wd;
        int kind;
        int k;
        int idx;
        int t;
        logic r;
        logic e;
        for (int j = 0; j < jobs; j++) begin
            tv[n] = 1'b0;
            repeat ($urandom_range(1, 4)) begin
                td[n] = 16'($urandom);
                step();
            end
            kind = $urandom_range(0, 3);
            k = kind < 2 ? $urandom_range(0, MAXL - 1) : (kind == 2 ? $urandom_range(1, MAXL - 1) : MAXL + 2);
            w.delete();
            for (int i = 0; i < k; i++) begin
                wd = 16'($urandom);
                if (wd == NAN) wd = 16'h1234;
                w.push_back(wd);
            end
            if (kind < 2) w.push_back(NAN);
            for (int i = 0; i < (kind == 3 ? MAXL : w.size()); i++) push(n, {1'b0, w[i]});
            if (kind >= 2) push(n, ERR);
            idx = 0;
            t = 0;
            while (idx < w.size() && t < 400) begin
                tv[n] = 1'b1;
                td[n] = w[idx];
                @(negedge clk);
                r = req_ready_o[n];
                e = req_err_o[n];
                step();
                t++;
                if (r) idx++;
                if (e) break;
            end
            if (t >= 400) begin
                n_chk++;
                n_fail++;
                $display("FAIL drv%0d_timeout: job %0d not completed within %0d cycles", n, j, t);
            end
        end
        tv[n] = 1'b0;
    endtask

    initial begin
        logic [15:0] seq[4];
        int done;
        seq = '{16'h1000, 16'h3c00, 16'h4000, NAN};
        rst = 1'b1;
        tv[0] = 1'b0;
        tv[1] = 1'b0;
        td[0] = 16'h0;
        td[1] = 16'h0;
        nn_i = 8'h5a;
        mon_en = 1'b0;
        fork
            monitor();
        join_none
        step();
        step();
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rdy_err", {28'd0, req_ready_o, req_err_o}, 32'd0);
        check("rst_nn", 32'(nn_data_o), 32'(IDLE));
        check("rst_rsp", {23'd0, rsp_valid_o, rsp_id_o, rsp_data_o}, 32'd0);
        rst = 1'b0;

        do_reset();
        tv[0] = 1'b1;
        td[0] = seq[0];
        @(negedge clk);
        check("r23_idle_rdy", 32'(req_ready_o), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            td[0] = seq[i];
            @(negedge clk);
            check("r23_rdy", 32'(req_ready_o), 32'd1);
            check("r23_nn", 32'(nn_data_o), 32'(seq[i]));
            step();
        end
        tv[0] = 1'b0;
        repeat (DC) begin
            @(negedge clk);
            check("r23_drain", {15'd0, busy_o, nn_data_o}, {15'd0, 1'b1, IDLE});
            step();
        end
        @(negedge clk);
        check("r23_idle", 32'(busy_o), 32'd0);

        do_reset();
        tv[0] = 1'b1;
        tv[1] = 1'b1;
        td[0] = NAN;
        td[1] = NAN;
        @(negedge clk);
        check("r24_idle_rdy", 32'(req_ready_o), 32'd0);
        step();
        @(negedge clk);
        check("r24_first", 32'(req_ready_o), 32'b01);
        step();
        repeat (DC) begin
            @(negedge clk);
            check("r24_drain_rdy", 32'(req_ready_o), 32'd0);
            step();
        end
        @(negedge clk);
        check("r24_gap", {30'd0, busy_o, |req_ready_o}, 32'd0);
        step();
        @(negedge clk);
        check("r24_second", 32'(req_ready_o), 32'b10);
        step();
        repeat (DC + 1) step();
        @(negedge clk);
        check("r24_third", 32'(req_ready_o), 32'b01);

        do_reset();
        tv[1] = 1'b1;
        td[1] = 16'h2001;
        @(negedge clk);
        check("r27_idle_rsp", 32'(rsp_valid_o), 32'd0);
        step();
        nn_i = 8'haa;
        @(negedge clk);
        check("r25_w1", {14'd0, req_ready_o, nn_data_o}, {14'd0, 2'b10, 16'h2001});
        check("r27_rsp_aa", {23'd0, rsp_valid_o, rsp_id_o, rsp_data_o}, {23'd0, 2'b11, 8'haa});
        step();
        nn_i = 8'h55;
        td[1] = 16'h2002;
        @(negedge clk);
        check("r25_w2", {14'd0, req_ready_o, nn_data_o}, {14'd0, 2'b10, 16'h2002});
        check("r27_rsp_55", {23'd0, rsp_valid_o, rsp_id_o, rsp_data_o}, {23'd0, 2'b11, 8'h55});
        step();
        tv[1] = 1'b0;
        @(negedge clk);
        check("r25_bubble", {12'd0, req_ready_o, req_err_o, nn_data_o}, {12'd0, 4'b0010, NAN});
        step();
        repeat (DC) begin
            @(negedge clk);
            check("r25_drain", {29'd0, busy_o, req_err_o}, 32'b100);
            step();
        end
        @(negedge clk);
        check("r27_idle", {30'd0, busy_o, rsp_valid_o}, 32'd0);

        do_reset();
        tv[0] = 1'b1;
        td[0] = 16'h3000;
        @(negedge clk);
        step();
        for (int i = 0; i < MAXL; i++) begin
            td[0] = 16'h3000 + 16'(i);
            @(negedge clk);
            check("ovf_accept", 32'(req_ready_o), 32'b01);
            step();
        end
        td[0] = 16'h3000 + 16'(MAXL);
        @(negedge clk);
        check("ovf_abort", {12'd0, req_ready_o, req_err_o, nn_data_o}, {12'd0, 4'b0001, NAN});
        step();
        @(negedge clk);
        check("ovf_one_err", 32'(req_err_o), 32'd0);
        tv[0] = 1'b0;

        do_reset();
        tv[0] = 1'b1;
        td[0] = 16'h4001;
        @(negedge clk);
        step();
        @(negedge clk);
        check("r28_issue1", 32'(req_ready_o), 32'b01);
        step();
        rst = 1'b1;
        td[0] = 16'h4002;
        step();
        @(negedge clk);
        check("r28_rst_outs", {11'd0, busy_o, req_ready_o, req_err_o, nn_data_o}, {16'd0, IDLE});
        check("r28_rst_rsp", {23'd0, rsp_valid_o, rsp_id_o, rsp_data_o}, 32'd0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("r28_regrant", {29'd0, busy_o, req_ready_o}, 32'b101);
        tv[0] = 1'b0;

        do_reset();
        mon_en = 1'b1;
        done = 0;
        fork
            begin
                drive(0, 40);
                done++;
            end
            begin
                drive(1, 40);
                done++;
            end
            begin
                while (done < 2) begin
                    nn_i = 8'($urandom);
                    step();
                end
            end
        join
        repeat (DC + 4) step();
        mon_en = 1'b0;
        check("sb_empty0", 32'(q0.size()), 32'd0);
        check("sb_empty1", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tiny_nn_job_arb.md
TINY_NN_JOB_ARB -- requirements
Module: tiny_nn_job_arb

Interface
REQ-001 Parameter: IdleWord, default 16'h0000, word driven to the datapath when no job is active; it shall decode as a no-op.
REQ-002 Parameter: NaNWord, default 16'h7e00, job terminator word, equal to the datapath's standard NaN.
REQ-003 Parameter: DrainCycles, default 6, number of IdleWord cycles after a terminator before the next grant; range 1..15.
REQ-004 Parameter: MaxJobLen, default 255, maximum number of words accepted per job, excluding the terminator; range 1..255.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 Ports, in order:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  2  per-requester word valid.
- req_data_i  in  32  requester n word at [16n+15:16n].
- req_ready_o  out  2  per-requester word accepted.
- req_err_o  out  2  one-cycle abort pulse per requester.
- nn_data_o  out  16  word to the datapath data input.
- nn_data_i  in  8  datapath byte output.
- rsp_valid_o  out  1  response byte valid.
- rsp_id_o  out  1  owner of the response byte.
- rsp_data_o  out  8  response byte.
- busy_o  out  1  high whenever state is not Idle.

Function
REQ-007 The block shall implement three states: Idle, Issue, Drain; it shall hold a grant register (1 bit), a round-robin priority pointer (1 bit), an 8-bit length counter and a 4-bit drain counter.
REQ-008 Idle: nn_data_o shall be IdleWord, req_ready_o shall be 0 and rsp_valid_o shall be 0.
REQ-009 Idle arbitration: if any req_valid_i bit is set, the block shall latch the grant and enter Issue on the next cycle, clear the length counter and accept no word that cycle.
REQ-010 With a single requester valid, that requester shall win; with both valid, the requester equal to the pointer shall win.
REQ-011 Issue: req_ready_o[grant] = req_valid_i[grant] and the other ready bit shall be 0.
REQ-012 Issue: nn_data_o shall equal req_data_i[grant] combinationally, and the length counter shall increment per accepted non-terminator word.
REQ-013 Issue, word accepted equal to NaNWord: the word shall be forwarded, the drain counter loaded with DrainCycles-1, and the next state shall be Drain.
REQ-014 Issue, req_valid_i[grant]=0 (bubble): nn_data_o shall be NaNWord and req_err_o[grant] shall pulse that cycle.
- The next state shall be Drain, and the requester shall have no further ready for this job.
REQ-015 Issue, length counter == MaxJobLen:
- req_ready_o shall be 0 and nn_data_o shall be NaNWord.
- req_err_o[grant] shall pulse and the next state shall be Drain.
- Overflow shall take priority over bubble; only one err pulse per job.
REQ-016 Drain:
- nn_data_o shall be IdleWord and req_ready_o shall be 0.
- Each cycle the drain counter shall decrement; in the cycle it reads 0 the next state shall be Idle and the pointer shall be set to ~grant.
REQ-017 In Issue and Drain, rsp_valid_o shall be 1, with rsp_id_o = grant and rsp_data_o = nn_data_i, unregistered.
- In Idle, rsp_data_o and rsp_id_o shall be 0.
REQ-018 A new grant shall never be issued in the cycle Drain exits.
- Minimum gap from a terminator to the first word of the next job: DrainCycles+2 cycles.
REQ-019 Changes on the non-granted requester's valid or data shall have no effect on any output.

Reset
REQ-020 While rst_i is high at a clock edge, the following shall hold after that edge:
- state Idle, pointer 0, grant 0, counters 0.
- req_ready_o=0, req_err_o=0, nn_data_o=IdleWord.
- rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0.
REQ-021 Reset mid-Issue or mid-Drain shall abandon the job with no err pulse and no terminator injection.
REQ-022 The first arbitration after reset shall favour requester 0.

Verification
REQ-023 Req0 streams 0x1000,0x3c00,0x4000,NaNWord back-to-back:
- ready high for 4 cycles starting one cycle after valid.
- nn_data_o mirrors the words, followed by 6 cycles of 0x0000, then Idle.
REQ-024 Both requesters valid at once after reset:
- req0 is granted first; req1 is granted in the first Idle cycle after req0 drains.
- Next tie goes to req0.
REQ-025 Req1 drops valid after 2 words:
- next cycle nn_data_o=0x7e00 and req_err_o=2'b10 for one cycle.
- Drain of 6 cycles follows.
REQ-026 MaxJobLen=3, req0 streams 5 non-terminator words:
- exactly 3 accepted, then 0x7e00 injected with ready 0 and req_err_o=2'b01.
REQ-027 Datapath byte stream 0xAA,0x55 during a req1 job:
- rsp_valid_o=1, rsp_id_o=1, rsp_data_o=0xAA then 0x55; rsp_valid_o=0 once Idle is reached.
REQ-028 rst_i asserted for 1 cycle in the 2nd Issue cycle:
- next cycle all outputs are at reset values, no err pulse.
- A still-valid req0 is re-granted on the following cycle.
